dna_score_max: RTL and testbench

Downstream consumer of the 16-PE systolic scoring array: it snoops the row-write strobe, the matrix address and the 16 per-row score words that the array presents to matrix memory. It keeps the highest cell score of the current alignment run and that cell's (row, column) position. It reports completion after the last matrix row, which gives software the local-alignment end point without reading back the whole matrix.

---
 rtl/dna_score_pkg.sv | 18 +
 rtl/dna_max16.sv | 38 +++
 rtl/dna_score_max.sv | 202 ++++++++++++++++++++
 tb/tb_dna_score_max.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dna_score_pkg.sv
// Shared constants and types for the DNA alignment max-score tracker.
package dna_score_pkg;

    localparam int unsigned NUM_PE      = 16;
    localparam int unsigned COL_W       = $clog2(NUM_PE);
    localparam int unsigned HIT_W       = COL_W + 1;
    localparam int unsigned SCORE_W_DEF = 32;

    localparam logic [SCORE_W_DEF-1:0] SCORE_MIN = {1'b1, {(SCORE_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/dna_max16.sv
// Combinational 16-to-1 signed max tree; ties resolve to the lowest column index.
module dna_max16
    import dna_score_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DEF
) (
    input  logic [NUM_PE-1:0][SCORE_W-1:0] scores_i,
    output logic [SCORE_W-1:0]             max_score_o,
    output logic [COL_W-1:0]               max_col_o
);

    // Heap-ordered tree: leaves at NUM_PE..2*NUM_PE-1, root at 1; left child holds lower columns.
    logic [SCORE_W-1:0] node_score [2*NUM_PE];
    logic [COL_W-1:0]   node_col   [2*NUM_PE];

    always_comb begin
        for (int i = 0; i < 2 * NUM_PE; i++) begin
            node_score[i] = '0;
            node_col[i]   = '0;
        end
        for (int i = 0; i < NUM_PE; i++) begin
            node_score[NUM_PE + i] = scores_i[i];
            node_col[NUM_PE + i]   = COL_W'(i);
        end
        for (int i = NUM_PE - 1; i >= 1; i--) begin
            if ($signed(node_score[2*i+1]) > $signed(node_score[2*i])) begin
                node_score[i] = node_score[2*i+1];
                node_col[i]   = node_col[2*i+1];
            end else begin
                node_score[i] = node_score[2*i];
                node_col[i]   = node_col[2*i];
            end
        end
        max_score_o = node_score[1];
        max_col_o   = node_col[1];
    end

endmodule

// File: rtl/dna_score_max.sv
// Tracks the best cell score and its (row, column) over one systolic-array alignment run.
// Optional feature: define DNA_SCORE_THRESH_EN to add a thresholded cell hit counter.
module dna_score_max
    import dna_score_pkg::*;
#(
    parameter int unsigned addr_start_matrix = 0,
    parameter int unsigned addr_end_matrix   = 30,
    parameter int unsigned SCORE_W           = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               W_matrix_i,
    input  logic [31:0]        addr_matrix_i,
    input  logic [SCORE_W-1:0] matrix_i0,
    input  logic [SCORE_W-1:0] matrix_i1,
    input  logic [SCORE_W-1:0] matrix_i2,
    input  logic [SCORE_W-1:0] matrix_i3,
    input  logic [SCORE_W-1:0] matrix_i4,
    input  logic [SCORE_W-1:0] matrix_i5,
    input  logic [SCORE_W-1:0] matrix_i6,
    input  logic [SCORE_W-1:0] matrix_i7,
    input  logic [SCORE_W-1:0] matrix_i8,
    input  logic [SCORE_W-1:0] matrix_i9,
    input  logic [SCORE_W-1:0] matrix_i10,
    input  logic [SCORE_W-1:0] matrix_i11,
    input  logic [SCORE_W-1:0] matrix_i12,
    input  logic [SCORE_W-1:0] matrix_i13,
    input  logic [SCORE_W-1:0] matrix_i14,
    input  logic [SCORE_W-1:0] matrix_i15,
`ifdef DNA_SCORE_THRESH_EN
    input  logic [SCORE_W-1:0] thresh_i,
    output logic [15:0]        hit_count_o,
`endif
    output logic [SCORE_W-1:0] max_score_o,
    output logic [31:0]        max_row_o,
    output logic [COL_W-1:0]   max_col_o,
    output logic [15:0]        rows_o,
    output logic               valid_o,
    output logic               done_o
);

    localparam logic [SCORE_W-1:0] MinScore = {1'b1, {(SCORE_W-1){1'b0}}};

    if (addr_end_matrix < addr_start_matrix) begin : g_bad_range
        $error("dna_score_max: addr_end_matrix below addr_start_matrix");
    end

    logic [NUM_PE-1:0][SCORE_W-1:0] scores;
    assign scores = {matrix_i15, matrix_i14, matrix_i13, matrix_i12,
                     matrix_i11, matrix_i10, matrix_i9,  matrix_i8,
                     matrix_i7,  matrix_i6,  matrix_i5,  matrix_i4,
                     matrix_i3,  matrix_i2,  matrix_i1,  matrix_i0};

    // Start edge detector: the registered pair adds one cycle before the clear takes effect.
    logic start_q1, start_q2, start_edge;
    assign start_edge = start_q1 & ~start_q2;

    state_e state_q, state_d;
    logic   accept;
    assign accept = (state_q == StRun) && W_matrix_i && !start_edge;

    always_comb begin
        state_d = state_q;
        if (start_edge) begin
            state_d = StRun;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StRun:   if (accept && (addr_matrix_i == addr_end_matrix)) state_d = StDrain;
                StDrain: state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    logic [SCORE_W-1:0] row_max;
    logic [COL_W-1:0]   row_col;

    dna_max16 #(
        .SCORE_W (SCORE_W)
    ) u_max16 (
        .scores_i    (scores),
        .max_score_o (row_max),
        .max_col_o   (row_col)
    );

    // Stage 1: per-row reduction result.
    logic               s1_valid_q;
    logic [SCORE_W-1:0] s1_score_q;
    logic [COL_W-1:0]   s1_col_q;
    logic [31:0]        s1_addr_q;

    // Stage 2: running result.
    logic [SCORE_W-1:0] max_score_q, max_score_d;
    logic [31:0]        max_row_q, max_row_d;
    logic [COL_W-1:0]   max_col_q, max_col_d;
    logic [15:0]        rows_q, rows_d;
    logic               valid_q, valid_d;

    always_comb begin
        max_score_d = max_score_q;
        max_row_d   = max_row_q;
        max_col_d   = max_col_q;
        rows_d      = rows_q;
        valid_d     = valid_q;
        if (start_edge) begin
            max_score_d = MinScore;
            max_row_d   = '0;
            max_col_d   = '0;
            rows_d      = '0;
            valid_d     = 1'b0;
        end else if (s1_valid_q) begin
            rows_d  = (rows_q == 16'hFFFF) ? rows_q : rows_q + 16'd1;
            valid_d = 1'b1;
            // Strict compare keeps the earlier row on ties.
            if ($signed(s1_score_q) > $signed(max_score_q)) begin
                max_score_d = s1_score_q;
                max_row_d   = s1_addr_q;
                max_col_d   = s1_col_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q1    <= 1'b0;
            start_q2    <= 1'b0;
            state_q     <= StIdle;
            s1_valid_q  <= 1'b0;
            s1_score_q  <= '0;
            s1_col_q    <= '0;
            s1_addr_q   <= '0;
            max_score_q <= '0;
            max_row_q   <= '0;
            max_col_q   <= '0;
            rows_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            start_q1    <= start_i;
            start_q2    <= start_q1;
            state_q     <= state_d;
            s1_valid_q  <= accept;
            if (accept) begin
                s1_score_q <= row_max;
                s1_col_q   <= row_col;
                s1_addr_q  <= addr_matrix_i;
            end
            max_score_q <= max_score_d;
            max_row_q   <= max_row_d;
            max_col_q   <= max_col_d;
            rows_q      <= rows_d;
            valid_q     <= valid_d;
        end
    end

`ifdef DNA_SCORE_THRESH_EN
    logic [HIT_W-1:0] row_hits;
    logic [HIT_W-1:0] s1_hits_q;
    logic [15:0]      hit_count_q, hit_count_d;
    logic [16:0]      hit_sum;

    always_comb begin
        row_hits = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if ($signed(scores[i]) >= $signed(thresh_i)) row_hits = row_hits + HIT_W'(1);
        end
    end

    assign hit_sum = {1'b0, hit_count_q} + 17'(s1_hits_q);

    always_comb begin
        hit_count_d = hit_count_q;
        if (start_edge) begin
            hit_count_d = '0;
        end else if (s1_valid_q) begin
            hit_count_d = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hits_q   <= '0;
            hit_count_q <= '0;
        end else begin
            if (accept) s1_hits_q <= row_hits;
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count_o = hit_count_q;
`endif

    assign max_score_o = max_score_q;
    assign max_row_o   = max_row_q;
    assign max_col_o   = max_col_q;
    assign rows_o      = rows_q;
    assign valid_o     = valid_q;
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_dna_score_max.sv
// Directed-vector bench for dna_score_max with hand-computed expectations.
module tb_dna_score_max;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, w;
    logic [31:0] addr;
    logic [31:0] mat [16];

    logic [31:0] max_score, max_row;
    logic [3:0]  max_col;
    logic [15:0] rows;
    logic        valid, done;
`ifdef DNA_SCORE_THRESH_EN
    logic [31:0] thresh;
    logic [15:0] hit_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    dna_score_max u_dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .W_matrix_i    (w),
        .addr_matrix_i (addr),
        .matrix_i0     (mat[0]),
        .matrix_i1     (mat[1]),
        .matrix_i2     (mat[2]),
        .matrix_i3     (mat[3]),
        .matrix_i4     (mat[4]),
        .matrix_i5     (mat[5]),
        .matrix_i6     (mat[6]),
        .matrix_i7     (mat[7]),
        .matrix_i8     (mat[8]),
        .matrix_i9     (mat[9]),
        .matrix_i10    (mat[10]),
        .matrix_i11    (mat[11]),
        .matrix_i12    (mat[12]),
        .matrix_i13    (mat[13]),
        .matrix_i14    (mat[14]),
        .matrix_i15    (mat[15]),
`ifdef DNA_SCORE_THRESH_EN
        .thresh_i      (thresh),
        .hit_count_o   (hit_count),
`endif
        .max_score_o   (max_score),
        .max_row_o     (max_row),
        .max_col_o     (max_col),
        .rows_o        (rows),
        .valid_o       (valid),
        .done_o        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 16; i++) mat[i] = v;
    endtask

    task automatic strobe(input logic [31:0] a);
        addr = a;
        w    = 1'b1;
        tick();
        w    = 1'b0;
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Background row: every cell 1, one cell (a%16) set to a%11, so never above 10.
    task automatic pattern_row(input int a);
        fill(32'd1);
        mat[a % 16] = 32'(a % 11);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        w     = 1'b0;
        addr  = '0;
        fill(32'd0);
`ifdef DNA_SCORE_THRESH_EN
        thresh = 32'd8;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_score", max_score, 32'd0);
        check("rst_row",   max_row,   32'd0);
        check("rst_col",   32'(max_col), 32'd0);
        check("rst_rows",  32'(rows),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done",  32'(done),  32'd0);

        // Single row, column 5 = 7
        restart();
        check("clr_score", max_score, 32'h8000_0000);
        check("clr_valid", 32'(valid), 32'd0);
        fill(32'd0);
        mat[5] = 32'd7;
        strobe(32'd0);
        check("lat_valid", 32'(valid), 32'd0);
        tick();
        check("one_score", max_score, 32'd7);
        check("one_row",   max_row,   32'd0);
        check("one_col",   32'(max_col), 32'd5);
        check("one_valid", 32'(valid), 32'd1);
        check("one_rows",  32'(rows),  32'd1);

        // Full run, tie between rows 12 and 20
        restart();
        for (int a = 0; a <= 30; a++) begin
            pattern_row(a);
            if (a == 12) mat[3] = 32'd40;
            if (a == 20) mat[9] = 32'd40;
            strobe(32'(a));
        end
        check("drain_done", 32'(done), 32'd0);
        tick();
        check("run_done",  32'(done),  32'd1);
        check("run_score", max_score, 32'd40);
        check("run_row",   max_row,   32'd12);
        check("run_col",   32'(max_col), 32'd3);
        check("run_rows",  32'(rows),  32'd31);

        // Strobes while done are ignored
        fill(32'd100);
        strobe(32'd5);
        strobe(32'd5);
        tick();
        check("idle_done",  32'(done),  32'd1);
        check("idle_score", max_score, 32'd40);
        check("idle_row",   max_row,   32'd12);
        check("idle_rows",  32'(rows),  32'd31);

        // Negative scores, all columns tie
        restart();
        check("neg_done_clr", 32'(done), 32'd0);
        fill(32'hFFFF_FFFD);
        strobe(32'd7);
        tick();
        check("neg_score", max_score, 32'hFFFF_FFFD);
        check("neg_col",   32'(max_col), 32'd0);
        check("neg_row",   max_row,   32'd7);
        check("neg_rows",  32'(rows),  32'd1);

        // Restart mid-run; strobe on the start-edge cycle must be dropped
        restart();
        for (int a = 0; a <= 9; a++) begin
            pattern_row(a);
            if (a == 5) mat[2] = 32'd50;
            strobe(32'(a));
        end
        fill(32'd60);
        addr  = 32'd10;
        w     = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        fill(32'd70);
        addr  = 32'd11;
        tick();
        w = 1'b0;
        check("mid_clr_rows",  32'(rows),  32'd0);
        check("mid_clr_valid", 32'(valid), 32'd0);
        for (int a = 0; a <= 30; a++) begin
            pattern_row(a);
            if (a == 3) mat[15] = 32'd20;
            strobe(32'(a));
        end
        tick();
        check("mid_done",  32'(done),  32'd1);
        check("mid_score", max_score, 32'd20);
        check("mid_row",   max_row,   32'd3);
        check("mid_col",   32'(max_col), 32'd15);
        check("mid_rows",  32'(rows),  32'd31);

`ifdef DNA_SCORE_THRESH_EN
        // Three rows, four cells >= 8 each; -20 must not count
        thresh = 32'd8;
        restart();
        check("hit_clr", 32'(hit_count), 32'd0);
        for (int a = 0; a < 3; a++) begin
            fill(32'd7);
            mat[0]  = 32'd8;
            mat[4]  = 32'd9;
            mat[9]  = 32'd100;
            mat[15] = 32'd8;
            mat[1]  = 32'hFFFF_FFEC;
            strobe(32'(a));
        end
        tick();
        check("hit_count", 32'(hit_count), 32'd12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
